// File: rtl/stack_alu.sv
// stack_alu: executes one opcode at a time against an external operand stack by sequencing pops and pushes.
// Define STACK_ALU_FAST_MUL_EN to use a single-cycle multiplier instead of the iterative MULT state.
//
// state | meaning
// IDLE  | ready for an opcode; operands and opcode latched on accept
// MULT  | iterative shift-add multiply, WIDTH+1 cycles
// POP2  | pop two operands
// POP1  | pop one operand, op done
// PUSHA | push r0
// PUSHB | push r1 (second push of SWAP)
// NOP   | done pulse for NOP
// ERR   | error pulse for a rejected opcode
module stack_alu #(
    parameter int DEPTH = 127,
    parameter int WIDTH = 31
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             op_valid,
    output logic             op_ready,
    input  logic [3:0]       op_code,
    input  logic [WIDTH:0]   op_imm,
    input  logic [WIDTH:0]   preview0,
    input  logic [WIDTH:0]   preview1,
    output logic             push,
    output logic [WIDTH:0]   push_data,
    output logic [2:0]       pop,
    output logic             done,
    output logic             error
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int MW = (WIDTH > 0) ? $clog2(WIDTH + 1) : 1;

    localparam logic [3:0] OP_NOP  = 4'd0;
    localparam logic [3:0] OP_PUSH = 4'd1;
    localparam logic [3:0] OP_POP  = 4'd2;
    localparam logic [3:0] OP_ADD  = 4'd3;
    localparam logic [3:0] OP_SUB  = 4'd4;
    localparam logic [3:0] OP_MUL  = 4'd5;
    localparam logic [3:0] OP_AND  = 4'd6;
    localparam logic [3:0] OP_OR   = 4'd7;
    localparam logic [3:0] OP_XOR  = 4'd8;
    localparam logic [3:0] OP_LT   = 4'd9;
    localparam logic [3:0] OP_DUP1 = 4'd10;
    localparam logic [3:0] OP_SWAP = 4'd11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_MULT,
        S_POP2,
        S_POP1,
        S_PUSHA,
        S_PUSHB,
        S_NOP,
        S_ERR
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   count_q, count_d;
    logic [3:0]      op_q, op_d;
    logic [WIDTH:0]  a_q, a_d;
    logic [WIDTH:0]  b_q, b_d;
    logic [WIDTH:0]  r0_q, r0_d;
    logic [WIDTH:0]  r1_q, r1_d;
    logic [MW-1:0]   cnt_q, cnt_d;

    logic [1:0]      need;
    logic            illegal;
    logic            grows;
    logic            reject;
    logic [WIDTH:0]  alu_res;

    always_comb begin
        need    = 2'd2;
        illegal = op_code > OP_SWAP;
        grows   = (op_code == OP_PUSH) || (op_code == OP_DUP1);
        case (op_code)
            OP_NOP, OP_PUSH: need = 2'd0;
            OP_POP, OP_DUP1: need = 2'd1;
            default:         need = 2'd2;
        endcase
        reject = illegal || (count_q < CW'(need)) || (grows && (count_q == CW'(DEPTH)));
    end

    always_comb begin
        alu_res = '0;
        case (op_code)
            OP_ADD: alu_res = preview0 + preview1;
            OP_SUB: alu_res = preview0 - preview1;
`ifdef STACK_ALU_FAST_MUL_EN
            OP_MUL: alu_res = preview0 * preview1;
`endif
            OP_AND: alu_res = preview0 & preview1;
            OP_OR:  alu_res = preview0 | preview1;
            OP_XOR: alu_res = preview0 ^ preview1;
            OP_LT:  alu_res = {{WIDTH{1'b0}}, (preview0 < preview1)};
            default: alu_res = '0;
        endcase
    end

    always_comb begin
        op_ready  = (state_q == S_IDLE) && !rst;
        push      = 1'b0;
        push_data = '0;
        pop       = 3'd0;
        done      = 1'b0;
        error     = 1'b0;
        // outputs are held quiet during reset so an abandoned op never touches the stack
        if (!rst) begin
            case (state_q)
                S_POP2: pop = 3'd2;
                S_POP1: begin
                    pop  = 3'd1;
                    done = 1'b1;
                end
                S_PUSHA: begin
                    push      = 1'b1;
                    push_data = r0_q;
                    done      = (op_q != OP_SWAP);
                end
                S_PUSHB: begin
                    push      = 1'b1;
                    push_data = r1_q;
                    done      = 1'b1;
                end
                S_NOP:   done  = 1'b1;
                S_ERR:   error = 1'b1;
                default: ;
            endcase
        end
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        r0_d    = r0_q;
        r1_d    = r1_q;
        cnt_d   = cnt_q;
        count_d = count_q + CW'(push) - CW'(pop);

        case (state_q)
            S_IDLE: begin
                if (op_valid && op_ready) begin
                    a_d  = preview0;
                    b_d  = preview1;
                    op_d = op_code;
                    if (reject) begin
                        state_d = S_ERR;
                    end else begin
                        case (op_code)
                            OP_NOP:  state_d = S_NOP;
                            OP_PUSH: begin
                                r0_d    = op_imm;
                                state_d = S_PUSHA;
                            end
                            OP_POP:  state_d = S_POP1;
                            OP_DUP1: begin
                                r0_d    = preview0;
                                state_d = S_PUSHA;
                            end
                            OP_SWAP: begin
                                r0_d    = preview0;
                                r1_d    = preview1;
                                state_d = S_POP2;
                            end
`ifndef STACK_ALU_FAST_MUL_EN
                            OP_MUL: begin
                                r0_d    = '0;
                                cnt_d   = MW'(WIDTH);
                                state_d = S_MULT;
                            end
`endif
                            default: begin
                                r0_d    = alu_res;
                                state_d = S_POP2;
                            end
                        endcase
                    end
                end
            end
            S_MULT: begin
                // a_q is the shifting multiplicand, b_q the multiplier consumed lsb first
                if (b_q[0]) begin
                    r0_d = r0_q + a_q;
                end
                a_d = a_q << 1;
                b_d = b_q >> 1;
                if (cnt_q == '0) begin
                    state_d = S_POP2;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_POP2:  state_d = S_PUSHA;
            S_PUSHA: state_d = (op_q == OP_SWAP) ? S_PUSHB : S_IDLE;
            S_POP1, S_PUSHB, S_NOP, S_ERR: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            count_q <= '0;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            r0_q    <= '0;
            r1_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            r0_q    <= r0_d;
            r1_q    <= r1_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_stack_alu.sv
// tb_stack_alu: drives stack_alu against a queue-based stack and checks each op with a reference model.
// Honours STACK_ALU_FAST_MUL_EN for the expected MUL latency.
module tb_stack_alu;

    localparam int DEPTH = 127;
    localparam int WIDTH = 31;

`ifdef STACK_ALU_FAST_MUL_EN
    localparam int MUL_BUSY = 2;
`else
    localparam int MUL_BUSY = WIDTH + 3;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        op_valid;
    logic        op_ready;
    logic [3:0]  op_code;
    logic [31:0] op_imm;
    logic [31:0] preview0;
    logic [31:0] preview1;
    logic        push;
    logic [31:0] push_data;
    logic [2:0]  pop;
    logic        done;
    logic        error;

    logic [31:0] stk[$];
    int          n_tests = 0;
    int          n_fail  = 0;

    always #5 clk = ~clk;

    stack_alu #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .op_valid  (op_valid),
        .op_ready  (op_ready),
        .op_code   (op_code),
        .op_imm    (op_imm),
        .preview0  (preview0),
        .preview1  (preview1),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .done      (done),
        .error     (error)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic refresh_preview();
        preview0 = (stk.size() > 0) ? stk[0] : 32'd0;
        preview1 = (stk.size() > 1) ? stk[1] : 32'd0;
    endtask

    // stack acts at the end of the cycle on whatever the DUT drives in it
    task automatic apply_stack();
        for (int i = 0; i < int'(pop); i++) begin
            if (stk.size() > 0) void'(stk.pop_front());
        end
        if (push) stk.push_front(push_data);
        refresh_preview();
    endtask

    function automatic logic [31:0] alu_ref(input logic [3:0] code, input logic [31:0] a, input logic [31:0] b);
        case (code)
            4'd3: return a + b;
            4'd4: return a - b;
            4'd5: return a * b;
            4'd6: return a & b;
            4'd7: return a | b;
            4'd8: return a ^ b;
            4'd9: return (a < b) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    task automatic run_op(input logic [3:0] code, input logic [31:0] imm, input string tag);
        logic [31:0] pre[$];
        logic [31:0] exp_q[$];
        logic [31:0] a, b;
        int  need, exp_busy, exp_pop_k, w, k;
        int  done_n, err_n, done_k, err_k, first_pop_k;
        bit  exp_err, both, binary;

        w = 0;
        while (!op_ready && w < 200) begin
            apply_stack();
            step();
            w++;
        end
        check_eq({tag, "_ready_wait"}, 32'(op_ready), 32'd1);

        pre   = stk;
        a     = (pre.size() > 0) ? pre[0] : 32'd0;
        b     = (pre.size() > 1) ? pre[1] : 32'd0;
        need  = (code <= 4'd1) ? 0 : ((code == 4'd2 || code == 4'd10) ? 1 : 2);
        binary = (code >= 4'd3 && code <= 4'd9);
        exp_err = (code > 4'd11) || (pre.size() < need) ||
                  ((code == 4'd1 || code == 4'd10) && pre.size() == DEPTH);
        exp_q = pre;
        exp_busy  = 1;
        exp_pop_k = 0;
        if (!exp_err) begin
            if (code == 4'd1) exp_q.push_front(imm);
            else if (code == 4'd2) begin
                void'(exp_q.pop_front());
                exp_pop_k = 1;
            end else if (code == 4'd10) exp_q.push_front(a);
            else if (binary) begin
                void'(exp_q.pop_front());
                void'(exp_q.pop_front());
                exp_q.push_front(alu_ref(code, a, b));
                exp_busy  = (code == 4'd5) ? MUL_BUSY : 2;
                exp_pop_k = exp_busy - 1;
            end else if (code == 4'd11) begin
                void'(exp_q.pop_front());
                void'(exp_q.pop_front());
                exp_q.push_front(a);
                exp_q.push_front(b);
                exp_busy  = 3;
                exp_pop_k = 1;
            end
        end

        op_valid = 1'b1;
        op_code  = code;
        op_imm   = imm;
        step();
        op_valid = 1'b0;
        op_code  = 4'd0;
        op_imm   = 32'd0;

        done_n = 0; err_n = 0; done_k = 0; err_k = 0; first_pop_k = 0; both = 1'b0;
        k = 1;
        while (!op_ready && k < 200) begin
            if (done) begin done_n++; done_k = k; end
            if (error) begin err_n++; err_k = k; end
            if (pop != 3'd0 && first_pop_k == 0) first_pop_k = k;
            if (push && pop != 3'd0) both = 1'b1;
            apply_stack();
            step();
            k++;
        end

        check_eq({tag, "_busy"},    32'(k - 1), 32'(exp_busy));
        check_eq({tag, "_err_n"},   32'(err_n), exp_err ? 32'd1 : 32'd0);
        check_eq({tag, "_done_n"},  32'(done_n), exp_err ? 32'd0 : 32'd1);
        check_eq({tag, "_pop_at"},  32'(first_pop_k), 32'(exp_pop_k));
        check_eq({tag, "_excl"},    32'(both), 32'd0);
        if (exp_err) check_eq({tag, "_err_at"}, 32'(err_k), 32'd1);
        else         check_eq({tag, "_done_at"}, 32'(done_k), 32'(exp_busy));
        check_eq({tag, "_depth"},   32'(stk.size()), 32'(exp_q.size()));
        check_eq({tag, "_top"},     (stk.size() > 0) ? stk[0] : 32'd0, (exp_q.size() > 0) ? exp_q[0] : 32'd0);
        check_eq({tag, "_second"},  (stk.size() > 1) ? stk[1] : 32'd0, (exp_q.size() > 1) ? exp_q[1] : 32'd0);
    endtask

    initial begin
        #900_000;
        $display("FAIL watchdog: simulation time limit reached, %0d tests run", n_tests);
        $fatal(1, "timeout");
    end

    initial begin
        int pushes;
        rst      = 1'b1;
        op_valid = 1'b0;
        op_code  = 4'd0;
        op_imm   = 32'd0;
        preview0 = 32'd0;
        preview1 = 32'd0;
        repeat (3) step();
        check_eq("rst_ready",     32'(op_ready), 32'd0);
        check_eq("rst_push",      32'(push), 32'd0);
        check_eq("rst_pop",       32'(pop), 32'd0);
        check_eq("rst_push_data", push_data, 32'd0);
        check_eq("rst_done",      32'(done), 32'd0);
        check_eq("rst_error",     32'(error), 32'd0);
        rst = 1'b0;
        step();
        check_eq("ready_after_rst", 32'(op_ready), 32'd1);

        run_op(4'd1, 32'd5, "push5");
        run_op(4'd1, 32'd7, "push7");
        run_op(4'd3, 32'd0, "add");
        check_eq("add_result", (stk.size() > 0) ? stk[0] : 32'd0, 32'd12);
        check_eq("add_depth", 32'(stk.size()), 32'd1);
        run_op(4'd2, 32'd0, "pop12");

        run_op(4'd1, 32'd10, "p10");
        run_op(4'd1, 32'd3, "p3");
        run_op(4'd4, 32'd0, "sub_wrap");
        check_eq("sub_wrap_val", (stk.size() > 0) ? stk[0] : 32'd0, 32'hFFFF_FFF9);
        run_op(4'd2, 32'd0, "pop_sw");
        run_op(4'd1, 32'd3, "q3");
        run_op(4'd1, 32'd10, "q10");
        run_op(4'd4, 32'd0, "sub");
        check_eq("sub_val", (stk.size() > 0) ? stk[0] : 32'd0, 32'd7);
        run_op(4'd2, 32'd0, "pop_s");

        run_op(4'd1, 32'd6, "m6");
        run_op(4'd1, 32'hFFFF_FFFF, "mff");
        run_op(4'd5, 32'd0, "mul");
        check_eq("mul_val", (stk.size() > 0) ? stk[0] : 32'd0, 32'hFFFF_FFFA);
        run_op(4'd2, 32'd0, "pop_m");

        run_op(4'd1, 32'd1, "s1");
        run_op(4'd1, 32'd2, "s2");
        run_op(4'd11, 32'd0, "swap");
        check_eq("swap_top",    (stk.size() > 0) ? stk[0] : 32'd0, 32'd1);
        check_eq("swap_second", (stk.size() > 1) ? stk[1] : 32'd0, 32'd2);
        run_op(4'd2, 32'd0, "pop_w1");
        run_op(4'd2, 32'd0, "pop_w2");

        run_op(4'd3, 32'd0, "empty_add");
        run_op(4'd2, 32'd0, "empty_pop");
        run_op(4'd13, 32'd0, "illegal13");
        run_op(4'd0, 32'd0, "nop");

        // reset during the POP2 cycle of an ADD
        run_op(4'd1, 32'd4, "r4");
        run_op(4'd1, 32'd9, "r9");
        op_valid = 1'b1;
        op_code  = 4'd3;
        step();
        op_valid = 1'b0;
        op_code  = 4'd0;
        rst = 1'b1;
        #1;
        check_eq("rst_mid_ready", 32'(op_ready), 32'd0);
        step();
        rst = 1'b0;
        #1;
        pushes = push ? 1 : 0;
        step();
        check_eq("rst_mid_ready_after", 32'(op_ready), 32'd1);
        repeat (3) begin
            if (push) pushes++;
            step();
        end
        check_eq("rst_mid_no_push", 32'(pushes), 32'd0);
        stk.delete();
        refresh_preview();

        for (int i = 0; i < DEPTH; i++) run_op(4'd1, $urandom, "fill");
        check_eq("fill_depth", 32'(stk.size()), 32'(DEPTH));
        run_op(4'd1, 32'd1, "full_push");
        run_op(4'd10, 32'd0, "full_dup");
        check_eq("full_depth", 32'(stk.size()), 32'(DEPTH));
        repeat (DEPTH - 3) run_op(4'd2, 32'd0, "drain");

        for (int i = 0; i < 300; i++) begin
            logic [3:0]  c;
            logic [31:0] v;
            if ($urandom_range(0, 9) == 0) c = 4'($urandom_range(12, 15));
            else if (stk.size() < 2 && $urandom_range(0, 2) != 0) c = 4'd1;
            else c = 4'($urandom_range(0, 11));
            v = $urandom;
            if ($urandom_range(0, 3) == 0) v = 32'($urandom_range(0, 15));
            run_op(c, v, "rand");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
